// File: rtl/pipelined_prefix_adder.sv
// Purpose: WIDTH-bit Kogge-Stone adder/subtractor with carry-in, cout and signed overflow, STAGES register stages.
// Latency: result valid after edge n+STAGES-1 for operands accepted at edge n; one op per cycle.
// Backpressure: global stall; in_ready = ~out_valid | out_ready, and every stage holds while it is low.
module pipelined_prefix_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Prefix depth and vector length; position 0 of every prefix vector is the carry-in slot (bit -1).
    localparam int L = $clog2(WIDTH);
    localparam int N = WIDTH + 1;

    // A register boundary follows prefix level m when some stage k maps onto it.
    function automatic logic is_cut(input int m);
        logic hit;
        hit = 1'b0;
        for (int k = 1; k < STAGES; k++) begin
            if ((k * L) / STAGES == m) hit = 1'b1;
        end
        return hit;
    endfunction

    logic             adv;
    logic [WIDTH-1:0] bb;
    logic             c0;

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;
    logic [N-1:0]     carry;

    assign adv      = ~out_valid_q | out_ready;
    assign in_ready = adv;

    // Subtraction is a + ~b + 1; the user carry-in is ignored in that mode.
    always_comb begin
        bb = sub ? ~b : b;
        c0 = sub ? 1'b1 : cin;
    end

    for (genvar m = 0; m <= L; m++) begin : g_stage
        logic [N-1:0]     g_c, p_c, g_o, p_o;
        logic [WIDTH-1:0] pb_c, pb_o;
        logic             v_c, v_o;

        if (m == 0) begin : g_gen
            // Level 0: bitwise generate/propagate with c0 injected as g[-1], p[-1]=0.
            assign g_c  = {a & bb, c0};
            assign p_c  = {a ^ bb, 1'b0};
            assign pb_c = a ^ bb;
            assign v_c  = in_valid;
        end else begin : g_comb
            localparam int D = 1 << (m - 1);
            // Kogge-Stone level: combine each position with the one D below it.
            always_comb begin
                g_c = g_stage[m-1].g_o;
                p_c = g_stage[m-1].p_o;
                for (int j = D; j < N; j++) begin
                    g_c[j] = g_stage[m-1].g_o[j] | (g_stage[m-1].p_o[j] & g_stage[m-1].g_o[j-D]);
                    p_c[j] = g_stage[m-1].p_o[j] & g_stage[m-1].p_o[j-D];
                end
            end
            assign pb_c = g_stage[m-1].pb_o;
            assign v_c  = g_stage[m-1].v_o;
        end

        if (is_cut(m)) begin : g_cut
            logic [N-1:0]     g_d, g_q, p_d, p_q;
            logic [WIDTH-1:0] pb_d, pb_q;
            logic             v_d, v_q;

            // Valid follows the global advance; data only loads behind a valid operand.
            always_comb begin
                v_d  = v_q;
                g_d  = g_q;
                p_d  = p_q;
                pb_d = pb_q;
                if (adv) begin
                    v_d = v_c;
                    if (v_c) begin
                        g_d  = g_c;
                        p_d  = p_c;
                        pb_d = pb_c;
                    end
                end
            end

            // Pipeline register after this prefix level.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q  <= 1'b0;
                    g_q  <= '0;
                    p_q  <= '0;
                    pb_q <= '0;
                end else begin
                    v_q  <= v_d;
                    g_q  <= g_d;
                    p_q  <= p_d;
                    pb_q <= pb_d;
                end
            end

            assign g_o  = g_q;
            assign p_o  = p_q;
            assign pb_o = pb_q;
            assign v_o  = v_q;
        end else begin : g_wire
            assign g_o  = g_c;
            assign p_o  = p_c;
            assign pb_o = pb_c;
            assign v_o  = v_c;
        end
    end

    // Carry into bit i sits at position i. When WIDTH is a power of two the top span stops at
    // position 1, so the c0 slot is folded in once more; elsewhere P already includes p[-1]=0.
    always_comb begin
        carry = g_stage[L].g_o | (g_stage[L].p_o & {N{g_stage[L].g_o[0]}});
    end

    // Output stage next-state: hold under stall, load results only behind a valid operand.
    always_comb begin
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        if (adv) begin
            out_valid_d = g_stage[L].v_o;
            if (g_stage[L].v_o) begin
                sum_d  = g_stage[L].pb_o ^ carry[WIDTH-1:0];
                cout_d = carry[WIDTH];
                ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];
            end
        end
    end

    // Final register stage holding the visible result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Purpose: self-checking bench for pipelined_prefix_adder with a queue scoreboard per DUT.
// Latency: directed DUT is 16b/2 stages, backpressure DUT 16b/3 stages, plus a width/stage sweep.
// Backpressure: random and directed out_ready stalls; every result is popped in order.
module tb_pipelined_prefix_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tot = 0;
    int bad = 0;
    int sw_fin = 0;
    localparam int NOPS = 400;
    localparam int NCFG = 25;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tot++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic sw_finish();
        sw_fin++;
    endtask

    // Behavioural reference: {cout, ovf, zero-extended sum}.
    function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic ci, input logic su);
        logic [63:0] mask, bb, s;
        logic [64:0] full;
        logic        c0, co, ov;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        bb   = (su ? ~b : b) & mask;
        c0   = su ? 1'b1 : ci;
        full = {1'b0, a & mask} + {1'b0, bb} + {64'd0, c0};
        s    = full[63:0] & mask;
        co   = full[w];
        ov   = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
        return {co, ov, s};
    endfunction

    function automatic logic [65:0] exp16(input logic co, input logic ov, input logic [15:0] s);
        return {co, ov, 48'd0, s};
    endfunction

    // ---------------- directed DUT: WIDTH=16, STAGES=2 ----------------
    logic        d_rst_n, d_in_valid, d_in_ready, d_cin, d_sub, d_out_valid, d_out_ready, d_cout, d_ovf;
    logic [15:0] d_a, d_b, d_sum;
    logic [65:0] d_q[$];

    pipelined_prefix_adder #(.WIDTH(16), .STAGES(2)) u_dut (
        .clk(clk), .rst_n(d_rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .a(d_a), .b(d_b), .cin(d_cin), .sub(d_sub), .out_valid(d_out_valid),
        .out_ready(d_out_ready), .sum(d_sum), .cout(d_cout), .ovf(d_ovf)
    );

    always @(negedge clk) begin
        if (d_out_valid && d_out_ready) begin
            if (d_q.size() == 0) check("d_unexpected_out", d_out_valid, 1'b0);
            else check("d_result", {d_cout, d_ovf, 48'd0, d_sum}, d_q.pop_front());
        end
    end

    // Presents one op from #1 after a rising edge; returns #1 after the accepting edge.
    task automatic d_send(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic su,
                          input logic [65:0] exp);
        int w;
        w = 0;
        d_a = a; d_b = b; d_cin = ci; d_sub = su; d_in_valid = 1'b1;
        @(negedge clk);
        while (!d_in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("d_accept", d_in_ready, 1'b1);
        d_q.push_back(exp);
        @(posedge clk);
        #1 d_in_valid = 1'b0;
    endtask

    // ---------------- backpressure DUT: WIDTH=16, STAGES=3 ----------------
    logic        b_in_valid, b_in_ready, b_cin, b_sub, b_out_valid, b_out_ready, b_cout, b_ovf;
    logic [15:0] b_a, b_b, b_sum;
    logic [65:0] b_q[$];
    int          b_rx = 0;

    pipelined_prefix_adder #(.WIDTH(16), .STAGES(3)) u_bp (
        .clk(clk), .rst_n(d_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .a(b_a), .b(b_b), .cin(b_cin), .sub(b_sub), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .sum(b_sum), .cout(b_cout), .ovf(b_ovf)
    );

    always @(negedge clk) begin
        if (b_out_valid && b_out_ready) begin
            if (b_q.size() == 0) check("bp_unexpected_out", b_out_valid, 1'b0);
            else check("bp_result", {b_cout, b_ovf, 48'd0, b_sum}, b_q.pop_front());
            b_rx++;
        end
    end

    // ---------------- random sweep over widths and every legal stage count ----------------
    logic s_rst_n;

    function automatic int swid(input int i);
        case (i)
            0: return 2;
            1: return 7;
            2: return 16;
            3: return 33;
            default: return 64;
        endcase
    endfunction

    for (genvar wi = 0; wi < 5; wi++) begin : g_w
        localparam int W  = swid(wi);
        localparam int LL = $clog2(W);
        for (genvar s = 1; s <= LL + 1; s++) begin : g_s
            logic         iv, ir, ov, orr, ci, su, co, of;
            logic [W-1:0] a, b, sm;
            logic [65:0]  q[$];

            pipelined_prefix_adder #(.WIDTH(W), .STAGES(s)) u_sw (
                .clk(clk), .rst_n(s_rst_n), .in_valid(iv), .in_ready(ir),
                .a(a), .b(b), .cin(ci), .sub(su), .out_valid(ov),
                .out_ready(orr), .sum(sm), .cout(co), .ovf(of)
            );

            initial begin
                int acc, rx, cyc;
                acc = 0; rx = 0; cyc = 0;
                iv = 1'b0; orr = 1'b0; a = '0; b = '0; ci = 1'b0; su = 1'b0;
                wait (s_rst_n === 1'b1);
                while ((acc < NOPS || rx < NOPS) && cyc < NOPS * 20) begin
                    @(posedge clk);
                    #1;
                    if (acc < NOPS) begin
                        iv = ($urandom_range(3) != 0);
                        a  = W'({$urandom, $urandom});
                        b  = W'({$urandom, $urandom});
                        ci = $urandom_range(1);
                        su = $urandom_range(1);
                        if ($urandom_range(7) == 0) a = '1;
                        if ($urandom_range(7) == 0) b = '1;
                    end else begin
                        iv = 1'b0;
                    end
                    orr = ($urandom_range(3) != 0);
                    @(negedge clk);
                    if (iv && ir) begin
                        q.push_back(model(W, 64'(a), 64'(b), ci, su));
                        acc++;
                    end
                    if (ov && orr) begin
                        if (q.size() == 0) check("sw_unexpected_out", ov, 1'b0);
                        else check($sformatf("sw_w%0d_s%0d", W, s), {co, of, 64'(sm)}, q.pop_front());
                        rx++;
                    end
                    cyc++;
                end
                check($sformatf("sw_w%0d_s%0d_count", W, s), rx, NOPS);
                sw_finish();
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int w;
        logic [18:0] snap;
        d_rst_n = 1'b0; s_rst_n = 1'b0;
        d_in_valid = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0; d_sub = 1'b0; d_out_ready = 1'b1;
        b_in_valid = 1'b0; b_a = '0; b_b = '0; b_cin = 1'b0; b_sub = 1'b0; b_out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", d_out_valid, 1'b0);
        check("rst_in_ready", d_in_ready, 1'b1);
        check("rst_result", {d_cout, d_ovf, d_sum}, 18'd0);
        check("rst_bp_out_valid", b_out_valid, 1'b0);
        @(negedge clk);
        d_rst_n = 1'b1;
        s_rst_n = 1'b1;

        // Latency: accepted at edge n, visible after edge n+1
        @(posedge clk);
        #1 d_a = 16'h00FF; d_b = 16'h0001; d_cin = 1'b0; d_sub = 1'b0; d_in_valid = 1'b1;
        @(negedge clk);
        check("lat_before_accept", d_out_valid, 1'b0);
        check("lat_in_ready", d_in_ready, 1'b1);
        @(posedge clk);
        #1 d_in_valid = 1'b0;
        d_q.push_back(exp16(1'b0, 1'b0, 16'h0100));
        @(negedge clk);
        check("lat_after_edge_n", d_out_valid, 1'b0);
        @(negedge clk);
        check("lat_after_edge_n1", d_out_valid, 1'b1);

        // Carry chain, overflow and subtract vectors
        @(posedge clk);
        #1;
        d_send(16'hFFFF, 16'h0000, 1'b1, 1'b0, exp16(1'b1, 1'b0, 16'h0000));
        d_send(16'h7FFF, 16'h0001, 1'b0, 1'b0, exp16(1'b0, 1'b1, 16'h8000));
        d_send(16'h0005, 16'h0007, 1'b1, 1'b1, exp16(1'b0, 1'b0, 16'hFFFE));
        d_send(16'h8000, 16'h0001, 1'b0, 1'b1, exp16(1'b1, 1'b1, 16'h7FFF));
        w = 0;
        while (d_q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("d_drain", d_q.size(), 0);

        // Backpressure: 8 back-to-back ops, 5-cycle stall mid-stream
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    int bw;
                    bw = 0;
                    b_a = 16'($urandom); b_b = 16'($urandom);
                    b_cin = $urandom_range(1); b_sub = i[0]; b_in_valid = 1'b1;
                    @(negedge clk);
                    while (!b_in_ready && bw < 50) begin
                        @(negedge clk);
                        bw++;
                    end
                    check("bp_accept", b_in_ready, 1'b1);
                    b_q.push_back(model(16, 64'(b_a), 64'(b_b), b_cin, b_sub));
                    @(posedge clk);
                    #1;
                end
                b_in_valid = 1'b0;
            end
            begin
                int sw;
                sw = 0;
                while (b_rx < 2 && sw < 100) begin
                    @(negedge clk);
                    sw++;
                end
                @(posedge clk);
                #1 b_out_ready = 1'b0;
                @(negedge clk);
                snap = {b_out_valid, b_cout, b_ovf, b_sum};
                check("bp_stall_valid", b_out_valid, 1'b1);
                check("bp_stall_in_ready", b_in_ready, 1'b0);
                repeat (4) begin
                    @(negedge clk);
                    check("bp_stall_in_ready", b_in_ready, 1'b0);
                    check("bp_stall_hold", {b_out_valid, b_cout, b_ovf, b_sum}, snap);
                end
                @(posedge clk);
                #1 b_out_ready = 1'b1;
            end
        join
        w = 0;
        while (b_rx < 8 && w < 100) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        check("bp_count", b_rx, 8);
        check("bp_queue_empty", b_q.size(), 0);

        // Reset with two ops in flight; neither may emerge afterwards
        @(posedge clk);
        #1 d_out_ready = 1'b0;
        d_a = 16'h1234; d_b = 16'h1111; d_cin = 1'b0; d_sub = 1'b0; d_in_valid = 1'b1;
        @(posedge clk);
        #1 d_a = 16'h4321; d_b = 16'h0101;
        @(posedge clk);
        #1 d_in_valid = 1'b0;
        #2 check("rr_in_flight", d_out_valid, 1'b1);
        #1 d_rst_n = 1'b0;
        #1;
        check("rr_out_valid", d_out_valid, 1'b0);
        check("rr_in_ready", d_in_ready, 1'b1);
        check("rr_result", {d_cout, d_ovf, d_sum}, 18'd0);
        @(negedge clk);
        d_rst_n = 1'b1;
        d_out_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("rr_after_release", d_out_valid, 1'b0);

        // Wait for the sweep
        w = 0;
        while (sw_fin < NCFG && w < 20000) begin
            @(negedge clk);
            w++;
        end
        check("sw_all_done", sw_fin, NCFG);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_prefix_adder.md
# pipelined_prefix_adder

Parametrised, pipelined parallel-prefix adder/subtractor with valid/ready flow control. It generalises the team's fixed 16-bit combinational prefix adders to any width and adds carry-in, a subtract mode, a signed-overflow flag and a configurable number of register stages. It sits between operand producers and result consumers in datapaths that need a full-throughput adder at high clock rates.

## Interface
- WIDTH, 16 — operand and sum width in bits (≥ 2).
- STAGES, 2 — register stages, 1 ≤ STAGES ≤ L+1, where L = ceil(log2(WIDTH)) is the prefix depth.

- clk  in  1  — single clock, all state on rising edge.
- rst_n  in  1  — asynchronous, active-low reset.
- in_valid  in  1  — operands present.
- in_ready  out  1  — block accepts operands this cycle.
- a  in  WIDTH  — operand A.
- b  in  WIDTH  — operand B.
- cin  in  1  — carry-in; ignored when sub=1.
- sub  in  1  — 1: compute a − b.
- out_valid  out  1  — result present.
- out_ready  in  1  — consumer accepts the result.
- sum  out  WIDTH  — result bits.
- cout  out  1  — carry out of bit WIDTH−1. For sub=1 this means no-borrow.
- ovf  out  1  — two's-complement signed overflow.

## Operation
- Effective operands: bb = sub ? ~b : b; c0 = sub ? 1 : cin.
- Bit level: g[i] = a[i] & bb[i] and p[i] = a[i] ^ bb[i].
  - c0 is folded in as g[−1] = c0, p[−1] = 0 at the LSB.
- Prefix network:
  - Kogge-Stone combine (G,P) ∘ (G',P') = (G | P&G', P&P').
  - L levels, where L = ceil(log2(WIDTH)).
- Outputs:
  - Carry into bit i is the group generate of [i−1 : −1].
  - sum[i] = p[i] ^ carry_i.
  - cout = carry into bit WIDTH.
  - ovf = carry_{WIDTH−1} ^ cout.
- Register placement:
  - Stage k (1 ≤ k ≤ STAGES−1) sits after prefix level floor(k·L/STAGES). Level 0 is the g/p generation.
  - The final stage registers sum, cout and ovf.
  - Each register stage carries a valid bit plus the p vector still needed downstream.
- Flow control is a global stall:
  - adv = ~out_valid | out_ready, and in_ready = adv (combinational).
  - When adv=1, every stage loads from its predecessor and stage 1 loads the input, with valid = in_valid.
  - When adv=0, every stage holds.
  - Bubbles are not collapsed. A full or partial pipeline behaves identically.
- Transfers:
  - An input transfer occurs on in_valid & in_ready.
  - An output transfer occurs on out_valid & out_ready.
- Data registers may be loaded only when the incoming valid is 1 (power saving). Their values while out_valid=0 are don't-care except after reset.

## Timing
- Reset (rst_n=0, asynchronous):
  - All stage valids clear, so out_valid=0 and in_ready=1.
  - sum, cout and ovf read 0.
  - In-flight operations are discarded with no partial output.
  - Release is synchronous to clk: the first acceptance can happen on the first rising edge after rst_n rises.
- Latency:
  - An operand accepted at edge n appears with out_valid=1 after edge n+STAGES−1 when there are no stalls. It is therefore visible in the cycle following edge n+STAGES−1.
  - STAGES=1 means one register: the result is valid the cycle after acceptance.
- Throughput is one operation per cycle while out_ready=1.
- Stall: with out_valid=1 and out_ready=0, in_ready=0 and all outputs hold stable until out_ready=1.
- Simultaneous output and input transfer in the same cycle is legal and loses nothing.
- sub and cin are sampled with a and b at acceptance. Changes while in_ready=0 have no effect.
- Ordering is strict FIFO; no reordering.

## Test plan
- Reset and latency (WIDTH=16, STAGES=2): a=0x00FF, b=0x0001, cin=0 accepted at edge n.
  - Required: sum=0x0100, cout=0, ovf=0, with out_valid first 1 after edge n+1.
  - Before that edge, out_valid=0 from reset.
- Carry chain and overflow (WIDTH=16): a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1.
- Subtract (WIDTH=16): a=0x0005, b=0x0007, sub=1, cin=1 (ignored) → sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
- Backpressure (STAGES=3): stream 8 back-to-back ops and hold out_ready=0 for 5 cycles mid-stream.
  - Required: in_ready=0 throughout the stall and outputs stable.
  - All 8 results arrive in order, with none dropped or duplicated.
- Reset mid-operation: assert rst_n=0 asynchronously with 2 ops in flight.
  - Required: out_valid=0 immediately, and neither op ever emerges after release.
- Parameter sweep:
  - WIDTH ∈ {2, 7, 16, 33, 64} × every legal STAGES.
  - 10k random operands with random in_valid/out_ready.
  - Compared against a behavioural a+b+cin / a−b model, including cout and ovf.
